regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port register file for the CPU datapath: 2 async read ports, 2 write ports
//  (W0 = ALU/commit, W1 = memory/multi-cycle writeback), optional write-to-read bypass and
//  hardwired zero register. A per-register busy scoreboard lets issue logic stall on in-flight results.
//  Sits between decode (reads, busy query, mark) and writeback (W0/W1).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; depth = 2**ADDR_W
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, is never busy
//  BYPASS    1   1: reads return same-cycle write data; 0: reads return stored value only
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  rst         in   1       synchronous reset, active-high
//  raddr1      in   ADDR_W  read port 1 address
//  raddr2      in   ADDR_W  read port 2 address
//  rdata1      out  DATA_W  read port 1 data (combinational)
//  rdata2      out  DATA_W  read port 2 data (combinational)
//  rbusy1      out  1       busy bit of raddr1 (combinational)
//  rbusy2      out  1       busy bit of raddr2 (combinational)
//  we0         in   1       write enable, port 0
//  waddr0      in   ADDR_W  write address, port 0
//  wdata0      in   DATA_W  write data, port 0
//  we1         in   1       write enable, port 1
//  waddr1      in   ADDR_W  write address, port 1
//  wdata1      in   DATA_W  write data, port 1
//  mark_en     in   1       set busy bit of mark_addr (instruction issued, result pending)
//  mark_addr   in   ADDR_W  register to mark busy
// BEHAVIOUR
//  - Reset: rst=1 at a rising edge clears every register to 0 and every busy bit to 0; writes and
//    marks in that cycle are discarded. After reset, rdata*=0 and rbusy*=0 for every address.
//  - Write: reg[waddrN] <= wdataN at rising edge when weN=1; write latency 1 cycle.
//  - Same-address double write (we0 & we1, waddr0==waddr1): W1 wins (older, longer-latency op
//    retires last in program order is NOT assumed; W1 is defined as priority port).
//  - Read, BYPASS=1: if weN & waddrN==raddrX (nonzero when ZERO_REG) rdataX = wdataN (W1 over W0),
//    else stored value. BYPASS=0: stored value only; new data visible the cycle after the edge.
//  - ZERO_REG=1: address 0 always reads 0, writes and marks to 0 ignored, rbusy for 0 always 0.
//  - Scoreboard: each register has busy bit. Rising edge: busy[mark_addr] <= 1 if mark_en;
//    busy[waddrN] <= 0 if weN. Mark and write to same address in same cycle: mark wins (busy stays 1).
//  - rbusyX reflects current busy bit; with BYPASS=1 it reads 0 when a same-cycle write to raddrX
//    clears it (and no same-cycle mark to that address), so dependents need not stall an extra cycle.
//  - Writes to non-busy registers are legal; busy bit stays 0.
//  - No X on outputs after first reset; reads of any address in range are always defined.
// TESTING
//  1 Reset: write 0xDEADBEEF to r5, assert rst 1 cycle -> rdata(r5)=0, rbusy=0 for all 32 regs.
//  2 Write/read: we0, r7<=0x12345678 -> BYPASS=1: rdata1=0x12345678 same cycle; BYPASS=0: next cycle.
//  3 Conflict: we0 r9<=0x1111, we1 r9<=0x2222 same cycle -> r9=0x2222 after edge.
//  4 Zero reg: we0 r0<=0xFFFFFFFF, mark_en r0 -> rdata(r0)=0, rbusy(r0)=0.
//  5 Scoreboard: mark r3 -> rbusy(r3)=1 next cycle; we1 r3<=0xAB -> rbusy=0 same cycle (BYPASS=1),
//    0 next cycle; mark+we0 to r4 same cycle -> rbusy(r4)=1 after edge.
//  6 Reset mid-op: mark r6 and we0 r6<=0x55 with rst=1 -> r6=0, busy[6]=0 after edge.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: two async read ports, two write ports (W1 has priority),
// optional write-to-read bypass, optional hardwired zero register and a per-register busy scoreboard.
module regfile_mp_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic              rbusy1,
   output logic              rbusy2,
   input  logic              we0,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              mark_en,
   input  logic [ADDR_W-1:0] mark_addr
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;

   logic w0_ok, w1_ok, mark_ok;
   logic [ADDR_W-1:0] raddr [2];
   logic [DATA_W-1:0] rdata [2];
   logic              rbusy [2];

   // Accesses aimed at the hardwired zero register are dropped here once for all consumers.
   assign w0_ok   = we0     && !(ZERO_REG && (waddr0    == '0));
   assign w1_ok   = we1     && !(ZERO_REG && (waddr1    == '0));
   assign mark_ok = mark_en && !(ZERO_REG && (mark_addr == '0));

   // Mark is applied last so it overrides a same-cycle clear.
   always_comb begin
      busy_d = busy_q;
      if (w0_ok)   busy_d[waddr0]    = 1'b0;
      if (w1_ok)   busy_d[waddr1]    = 1'b0;
      if (mark_ok) busy_d[mark_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         if (w0_ok) regs_q[waddr0] <= wdata0;
         // W1 is the priority port: its write lands after W0's on an address clash.
         if (w1_ok) regs_q[waddr1] <= wdata1;
         busy_q <= busy_d;
      end
   end

   assign raddr[0] = raddr1;
   assign raddr[1] = raddr2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = regs_q[raddr[p]];
         rbusy[p] = busy_q[raddr[p]];
         if (BYPASS) begin
            if (w0_ok && (waddr0 == raddr[p])) rdata[p] = wdata0;
            if (w1_ok && (waddr1 == raddr[p])) rdata[p] = wdata1;
            // A retiring write releases dependents in the same cycle unless re-marked.
            if (((w0_ok && (waddr0 == raddr[p])) || (w1_ok && (waddr1 == raddr[p]))) &&
                !(mark_ok && (mark_addr == raddr[p]))) begin
               rbusy[p] = 1'b0;
            end
         end
         if (ZERO_REG && (raddr[p] == '0)) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
         end
      end
   end

   assign rdata1 = rdata[0];
   assign rdata2 = rdata[1];
   assign rbusy1 = rbusy[0];
   assign rbusy2 = rbusy[1];

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: one instance with bypass, one without, sharing all inputs.
module tb_regfile_mp_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  raddr1, raddr2, waddr0, waddr1, mark_addr;
   logic        we0, we1, mark_en;
   logic [31:0] wdata0, wdata1;
   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic        rb1_b, rb2_b, rb1_n, rb2_n;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_byp (
      .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rd1_b), .rdata2(rd2_b), .rbusy1(rb1_b), .rbusy2(rb2_b),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .mark_en(mark_en), .mark_addr(mark_addr)
   );

   regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nob (
      .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rd1_n), .rdata2(rd2_n), .rbusy1(rb1_n), .rbusy2(rb2_n),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .mark_en(mark_en), .mark_addr(mark_addr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; mark_en = 1'b0; rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; we0 = 1'b0; we1 = 1'b0; mark_en = 1'b0;
      raddr1 = '0; raddr2 = '0; waddr0 = '0; waddr1 = '0; mark_addr = '0;
      wdata0 = '0; wdata1 = '0;
      tick();
      idle();

      // 1: write and mark r5, then reset clears data and every busy bit
      we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
      mark_en = 1'b1; mark_addr = 5'd5;
      tick();
      idle();
      raddr1 = 5'd5;
      #1;
      check("r5_written", rd1_b, 32'hDEADBEEF);
      check("r5_busy_pre_rst", {31'd0, rb1_b}, 32'd1);
      rst = 1'b1;
      tick();
      idle();
      #1;
      check("r5_after_rst", rd1_b, 32'h0);
      check("r5_after_rst_nob", rd1_n, 32'h0);
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i);
         raddr2 = 5'(31 - i);
         #1;
         check($sformatf("rst_busy1_r%0d", i), {30'd0, rb1_b, rb1_n}, 32'd0);
         check($sformatf("rst_busy2_r%0d", 31 - i), {30'd0, rb2_b, rb2_n}, 32'd0);
         check($sformatf("rst_data_r%0d", i), rd1_b | rd1_n, 32'h0);
      end

      // 2: write r7, bypass visible same cycle, stored value next cycle
      we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h12345678; raddr1 = 5'd7;
      #1;
      check("r7_bypass_same", rd1_b, 32'h12345678);
      check("r7_nobypass_same", rd1_n, 32'h0);
      tick();
      idle();
      #1;
      check("r7_bypass_next", rd1_b, 32'h12345678);
      check("r7_nobypass_next", rd1_n, 32'h12345678);

      // 3: both ports write r9, W1 wins
      we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h1111;
      we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h2222; raddr2 = 5'd9;
      #1;
      check("r9_bypass_w1", rd2_b, 32'h2222);
      tick();
      idle();
      #1;
      check("r9_stored_byp", rd2_b, 32'h2222);
      check("r9_stored_nob", rd2_n, 32'h2222);

      // 4: zero register ignores writes and marks
      we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
      mark_en = 1'b1; mark_addr = 5'd0; raddr1 = 5'd0;
      #1;
      check("r0_same_data", rd1_b, 32'h0);
      check("r0_same_busy", {31'd0, rb1_b}, 32'd0);
      tick();
      idle();
      #1;
      check("r0_data", rd1_b | rd1_n, 32'h0);
      check("r0_busy", {30'd0, rb1_b, rb1_n}, 32'd0);

      // 5: scoreboard mark / clear / mark-wins
      mark_en = 1'b1; mark_addr = 5'd3; raddr1 = 5'd3;
      #1;
      check("r3_busy_before_edge", {31'd0, rb1_b}, 32'd0);
      tick();
      idle();
      #1;
      check("r3_busy_byp", {31'd0, rb1_b}, 32'd1);
      check("r3_busy_nob", {31'd0, rb1_n}, 32'd1);
      we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hAB;
      #1;
      check("r3_clear_same_byp", {31'd0, rb1_b}, 32'd0);
      check("r3_clear_same_nob", {31'd0, rb1_n}, 32'd1);
      check("r3_data_same_byp", rd1_b, 32'hAB);
      tick();
      idle();
      #1;
      check("r3_busy_next", {30'd0, rb1_b, rb1_n}, 32'd0);
      check("r3_data_next", rd1_n, 32'hAB);
      mark_en = 1'b1; mark_addr = 5'd4;
      we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44; raddr2 = 5'd4;
      #1;
      check("r4_busy_same", {31'd0, rb2_b}, 32'd0);
      tick();
      idle();
      #1;
      check("r4_mark_wins_byp", {31'd0, rb2_b}, 32'd1);
      check("r4_mark_wins_nob", {31'd0, rb2_n}, 32'd1);
      check("r4_data", rd2_n, 32'h44);

      // 6: mark and write during reset are discarded
      rst = 1'b1; mark_en = 1'b1; mark_addr = 5'd6;
      we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h55; raddr1 = 5'd6; raddr2 = 5'd4;
      tick();
      idle();
      #1;
      check("r6_rst_data", rd1_b | rd1_n, 32'h0);
      check("r6_rst_busy", {30'd0, rb1_b, rb1_n}, 32'd0);
      check("r4_rst_busy", {30'd0, rb2_b, rb2_n}, 32'd0);
      check("r4_rst_data", rd2_b | rd2_n, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
